// File: rtl/ieee80211_defs_pkg.sv
// ============================================================================
// Module      : ieee80211_defs (package)
// Description : 802.11a RATE codes, coded-bit lookups and interleaver index map
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ieee80211_defs;

    localparam int CODED_WIDTH = 48;
    localparam int c_MAX_CBPS  = 288;

    localparam logic [3:0] c_RATE_6  = 4'b1101;
    localparam logic [3:0] c_RATE_9  = 4'b1111;
    localparam logic [3:0] c_RATE_12 = 4'b0101;
    localparam logic [3:0] c_RATE_18 = 4'b0111;
    localparam logic [3:0] c_RATE_24 = 4'b1001;
    localparam logic [3:0] c_RATE_36 = 4'b1011;
    localparam logic [3:0] c_RATE_48 = 4'b0001;
    localparam logic [3:0] c_RATE_54 = 4'b0011;

    typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_FULL} fill_state_t;
    typedef enum logic       {ST_IDLE, ST_SEND}          drain_state_t;

    // Mode 0..3 = BPSK, QPSK, 16-QAM, 64-QAM; unknown codes fall back to BPSK
    function automatic logic [1:0] rate_to_mode(input logic [3:0] rate);
        case (rate)
            c_RATE_12, c_RATE_18: return 2'd1;
            c_RATE_24, c_RATE_36: return 2'd2;
            c_RATE_48, c_RATE_54: return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] mode_nw(input logic [1:0] mode);
        case (mode)
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            2'd3:    return 3'd6;
            default: return 3'd1;
        endcase
    endfunction

    function automatic int unsigned mode_ncbps(input logic [1:0] mode);
        return CODED_WIDTH * int'(mode_nw(mode));
    endfunction

    function automatic int unsigned mode_nbpsc(input logic [1:0] mode);
        case (mode)
            2'd1:    return 2;
            2'd2:    return 4;
            2'd3:    return 6;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned perm_index(input logic [1:0] mode, input int unsigned k);
        int unsigned n;
        int unsigned s;
        int unsigned i;
        n = mode_ncbps(mode);
        s = (mode_nbpsc(mode) > 2) ? mode_nbpsc(mode) / 2 : 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/interleaver_perm.sv
// ============================================================================
// Module      : interleaver_perm
// Description : Combinational 802.11a two-step permutation of one 288-bit symbol
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interleaver_perm
    import ieee80211_defs::*;
(
    input  logic [c_MAX_CBPS-1:0] i_buf,
    input  logic [1:0]            i_mode,
    output logic [c_MAX_CBPS-1:0] o_perm
);

    logic [3:0][c_MAX_CBPS-1:0] w_perm;

    // Each mode is a fixed wiring; bits beyond N_CBPS read as zero
    for (genvar m = 0; m < 4; m++) begin : g_mode
        for (genvar k = 0; k < c_MAX_CBPS; k++) begin : g_bit
            if (k < mode_ncbps(2'(m))) begin : g_map
                assign w_perm[m][perm_index(2'(m), k)] = i_buf[k];
            end else begin : g_pad
                assign w_perm[m][k] = 1'b0;
            end
        end
    end

    assign o_perm = w_perm[i_mode];

endmodule

`default_nettype wire

// File: rtl/interleaver.sv
// ============================================================================
// Module      : interleaver
// Description : 802.11a block interleaver, AXI-Stream in/out, one OFDM symbol
//               per permutation. INTERLEAVER_PINGPONG_EN enables two buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interleaver
    import ieee80211_defs::*;
#(
    parameter int WIDTH = 24
)
(
    input  logic               aclk,
    input  logic               areset,
    input  logic [2*WIDTH-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic [3:0]         s_axis_tuser,
    output logic [2*WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [3:0]         m_axis_tuser
);

`ifdef INTERLEAVER_PINGPONG_EN
    localparam bit c_PINGPONG = 1'b1;
`else
    localparam bit c_PINGPONG = 1'b0;
`endif

    logic [c_MAX_CBPS-1:0] r_buf [2];
    logic [1:0]            r_mode [2];
    logic [3:0]            r_rate [2];
    logic [1:0]            r_last;
    logic [1:0]            r_full;
    logic                  r_wp;
    logic                  r_rp;
    logic [2:0]            r_wcnt;
    logic [2:0]            r_ld;
    logic [1:0]            r_cur_mode;
    logic [2*WIDTH-1:0]    r_tdata;
    logic                  r_tlast;
    logic [3:0]            r_tuser;
    fill_state_t           r_fstate;
    fill_state_t           w_fstate_nxt;
    drain_state_t          r_dstate;
    drain_state_t          w_dstate_nxt;

    logic                  w_in_fire;
    logic                  w_in_first;
    logic [1:0]            w_in_mode;
    logic                  w_in_done;
    logic                  w_load;
    logic                  w_ld_final;
    logic                  w_out_fire;
    logic                  w_wp_nxt;
    logic [1:0]            w_full_nxt;
    logic [c_MAX_CBPS-1:0] w_perm;

    assign w_in_fire  = s_axis_tvalid & s_axis_tready;
    assign w_in_first = (r_wcnt == 3'd0);
    assign w_in_mode  = w_in_first ? rate_to_mode(s_axis_tuser) : r_cur_mode;
    assign w_in_done  = w_in_fire & (s_axis_tlast | (r_wcnt == mode_nw(w_in_mode) - 3'd1));
    assign w_wp_nxt   = (w_in_done & c_PINGPONG) ? ~r_wp : r_wp;

    // A buffer is released as soon as its last word is copied to the output register
    assign w_load     = r_full[r_rp] & ((r_dstate == ST_IDLE) | m_axis_tready);
    assign w_ld_final = w_load & (r_ld == mode_nw(r_mode[r_rp]) - 3'd1);
    assign w_out_fire = (r_dstate == ST_SEND) & m_axis_tready;

    always_comb begin
        w_full_nxt = r_full;
        if (w_ld_final) w_full_nxt[r_rp] = 1'b0;
        if (w_in_done)  w_full_nxt[r_wp] = 1'b1;
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        if (w_load)
            w_dstate_nxt = ST_SEND;
        else if (w_out_fire)
            w_dstate_nxt = ST_IDLE;
    end

    // Single-buffer mode also blocks input until the final output word is taken
    always_comb begin
        w_fstate_nxt = ST_FILL;
        if (w_full_nxt[w_wp_nxt] || (!c_PINGPONG && (w_dstate_nxt == ST_SEND)))
            w_fstate_nxt = ST_FULL;
    end

    interleaver_perm u_perm (
        .i_buf  (r_buf[r_rp]),
        .i_mode (r_mode[r_rp]),
        .o_perm (w_perm)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_fstate   <= ST_INIT;
            r_dstate   <= ST_IDLE;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_mode[0]  <= '0;
            r_mode[1]  <= '0;
            r_rate[0]  <= '0;
            r_rate[1]  <= '0;
            r_last     <= '0;
            r_full     <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_wcnt     <= '0;
            r_ld       <= '0;
            r_cur_mode <= '0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= '0;
        end else begin
            r_fstate <= w_fstate_nxt;
            r_dstate <= w_dstate_nxt;
            r_full   <= w_full_nxt;
            r_wp     <= w_wp_nxt;
            if (w_in_fire) begin
                if (w_in_first) begin
                    r_buf[r_wp]  <= {{(c_MAX_CBPS-CODED_WIDTH){1'b0}}, s_axis_tdata};
                    r_mode[r_wp] <= w_in_mode;
                    r_rate[r_wp] <= s_axis_tuser;
                    r_cur_mode   <= w_in_mode;
                end else begin
                    r_buf[r_wp][r_wcnt*CODED_WIDTH +: CODED_WIDTH] <= s_axis_tdata;
                end
                r_last[r_wp] <= s_axis_tlast;
                r_wcnt       <= w_in_done ? 3'd0 : r_wcnt + 3'd1;
            end
            if (w_load) begin
                r_tdata <= w_perm[r_ld*CODED_WIDTH +: CODED_WIDTH];
                r_tlast <= w_ld_final & r_last[r_rp];
                r_tuser <= r_rate[r_rp];
                if (w_ld_final) begin
                    r_ld <= 3'd0;
                    if (c_PINGPONG) r_rp <= ~r_rp;
                end else begin
                    r_ld <= r_ld + 3'd1;
                end
            end
        end
    end

    assign s_axis_tready = (r_fstate == ST_FILL);
    assign m_axis_tvalid = (r_dstate == ST_SEND);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule

`default_nettype wire

// File: tb/tb_interleaver.sv
// ============================================================================
// Module      : tb_interleaver
// Description : Scoreboard bench for interleaver against a formula-level model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interleaver;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [47:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [3:0]  s_axis_tuser = '0;
    logic [47:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tuser;

    interleaver #(.WIDTH(24)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [47:0] data;
        logic        last;
        logic [3:0]  user;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int    total = 0;
    int    bad = 0;
    bit    rnd_ready = 1'b0;
    bit    hold_low = 1'b0;
    bit    chk_rdy = 1'b0;
    bit    stall_prev = 1'b0;
    logic [47:0] pd;
    logic        pl;
    logic [3:0]  pu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Words per symbol and bits per subcarrier, straight from the RATE table
    function automatic int tb_nw(input logic [3:0] rate);
        case (rate)
            4'b0101, 4'b0111: return 2;
            4'b1001, 4'b1011: return 4;
            4'b0001, 4'b0011: return 6;
            default:          return 1;
        endcase
    endfunction

    function automatic int tb_bpsc(input logic [3:0] rate);
        case (rate)
            4'b0101, 4'b0111: return 2;
            4'b1001, 4'b1011: return 4;
            4'b0001, 4'b0011: return 6;
            default:          return 1;
        endcase
    endfunction

    task automatic push_model(input logic [3:0] rate, input logic [47:0] w[$], input bit last);
        logic [287:0] inb;
        logic [287:0] outb;
        beat_t b;
        int n, s, i, j;
        n = 48 * tb_nw(rate);
        s = (tb_bpsc(rate) / 2 > 1) ? tb_bpsc(rate) / 2 : 1;
        inb = '0;
        outb = '0;
        foreach (w[x]) inb[48*x +: 48] = w[x];
        for (int k = 0; k < n; k++) begin
            i = (n / 16) * (k % 16) + k / 16;
            j = s * (i / s) + (i + n - (16 * i) / n) % s;
            outb[j] = inb[k];
        end
        for (int v = 0; v < n / 48; v++) begin
            b.data = outb[48*v +: 48];
            b.last = last && (v == n / 48 - 1);
            b.user = rate;
            exp_q.push_back(b);
        end
    endtask

    task automatic push_exp(input logic [47:0] d0, input int nw, input logic [3:0] rate);
        beat_t b;
        for (int v = 0; v < nw; v++) begin
            b.data = (v == 0) ? d0 : 48'h0;
            b.last = (v == nw - 1);
            b.user = rate;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_word(input logic [47:0] d, input logic [3:0] u, input bit l, input bit gap);
        int t;
        if (gap && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        t = 0;
        while (!s_axis_tready && t < 2000) begin
            @(posedge aclk); #1;
            t++;
        end
        if (t >= 2000) chk("in_ready_timeout", 64'(s_axis_tready), 64'd1);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // tuser is scrambled after the first word: it must be ignored mid-symbol
    task automatic send_sym(input logic [3:0] rate, input logic [47:0] w[$], input bit last, input bit gap);
        for (int x = 0; x < w.size(); x++)
            send_word(w[x], (x == 0) ? rate : 4'($urandom), last && (x == w.size() - 1), gap);
    endtask

    task automatic rand_sym(input bit gap, input logic [3:0] rate, input bit full);
        logic [47:0] w[$];
        int nw, len;
        bit last;
        nw   = tb_nw(rate);
        len  = (!full && $urandom_range(0, 2) == 0) ? $urandom_range(1, nw) : nw;
        last = (len < nw) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int x = 0; x < len; x++) w.push_back({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
        send_sym(rate, w, last, gap);
        push_model(rate, w, last);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge aclk); #1;
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge aclk); #1;
            m_axis_tready = hold_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    always @(negedge aclk) begin
        if (areset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
                chk("hold_data", 64'(m_axis_tdata), 64'(pd));
                chk("hold_last", 64'(m_axis_tlast), 64'(pl));
                chk("hold_user", 64'(m_axis_tuser), 64'(pu));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(m_axis_tvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("out_last", 64'(m_axis_tlast), 64'(e.last));
                    chk("out_user", 64'(m_axis_tuser), 64'(e.user));
                end
            end
`ifdef INTERLEAVER_PINGPONG_EN
            if (chk_rdy) chk("pp_ready_high", 64'(s_axis_tready), 64'd1);
`else
            if (m_axis_tvalid) chk("single_ready_low", 64'(s_axis_tready), 64'd0);
`endif
            stall_prev = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            pu = m_axis_tuser;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] w[$];
        repeat (3) @(negedge aclk);
        chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_data", 64'(m_axis_tdata), 64'd0);
        chk("rst_m_last", 64'(m_axis_tlast), 64'd0);
        chk("rst_m_user", 64'(m_axis_tuser), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        chk("ready_before_edge", 64'(s_axis_tready), 64'd0);
        @(posedge aclk); #1;
        chk("ready_after_edge", 64'(s_axis_tready), 64'd1);

        w = '{48'h2};
        send_sym(4'b1101, w, 1'b1, 1'b0);
        push_exp(48'h8, 1, 4'b1101);
        chk("latency_not_yet", 64'(m_axis_tvalid), 64'd0);
        @(posedge aclk); #1;
        chk("latency_valid", 64'(m_axis_tvalid), 64'd1);
        wait_drain();

        w = '{48'h2, 48'h0};
        send_sym(4'b0101, w, 1'b1, 1'b0);
        push_exp(48'h40, 2, 4'b0101);
        w = '{48'h1_0000, 48'h0};
        send_sym(4'b0101, w, 1'b1, 1'b0);
        push_exp(48'h2, 2, 4'b0101);
        w = '{48'h2, 48'h0, 48'h0, 48'h0};
        send_sym(4'b1001, w, 1'b1, 1'b0);
        push_exp(48'h2000, 4, 4'b1001);
        w = '{48'h2, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
        send_sym(4'b0011, w, 1'b1, 1'b0);
        push_exp(48'h10_0000, 6, 4'b0011);
        w = '{48'h1, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
        send_sym(4'b0011, w, 1'b1, 1'b0);
        push_exp(48'h1, 6, 4'b0011);
        w = '{48'h1234_5678_9ABC, 48'hFFFF_FFFF_FFFF, 48'h0F0F_00FF_A5A5};
        send_sym(4'b0001, w, 1'b1, 1'b0);
        push_model(4'b0001, w, 1'b1);
        w = '{48'hDEAD_BEEF_CAFE};
        send_sym(4'b0000, w, 1'b0, 1'b0);
        push_model(4'b0000, w, 1'b0);
        wait_drain();

        rnd_ready = 1'b1;
        repeat (40) rand_sym(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        wait_drain();

        // Stranded symbol (and a partial one where buffering allows) must vanish on reset
        hold_low = 1'b1;
        @(posedge aclk); #1;
        w = '{48'h5555_AAAA_5555};
        send_sym(4'b1101, w, 1'b1, 1'b0);
`ifdef INTERLEAVER_PINGPONG_EN
        send_word(48'h1111_2222_3333, 4'b0001, 1'b0, 1'b0);
        send_word(48'h4444_5555_6666, 4'b0001, 1'b0, 1'b0);
`endif
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b1;
        exp_q.delete();
        @(posedge aclk); #1;
        chk("midrst_m_valid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_s_ready", 64'(s_axis_tready), 64'd0);
        areset = 1'b0;
        hold_low = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge aclk); #1;
            chk("no_stale_out", 64'(m_axis_tvalid), 64'd0);
        end

        repeat (30) rand_sym(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        wait_drain();

        rnd_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
`ifdef INTERLEAVER_PINGPONG_EN
        chk_rdy = 1'b1;
`endif
        repeat (3) rand_sym(1'b0, 4'b0001, 1'b1);
        chk_rdy = 1'b0;
        wait_drain();
`ifdef INTERLEAVER_PINGPONG_EN
        chk_rdy = 1'b1;
`endif
        repeat (4) rand_sym(1'b0, 4'b1101, 1'b1);
        chk_rdy = 1'b0;
        wait_drain();
        repeat (5) @(posedge aclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interleaver.md
# interleaver

Block interleaver for the IEEE 802.11a transmit chain, directly downstream of the scrambler/convolutional-encoder system. It accepts 2*WIDTH-bit rate-1/2 coded words over AXI-Stream and collects one OFDM symbol of N_CBPS coded bits, with N_CBPS selected by the 4-bit RATE field on tuser. It applies the standard two-step 802.11a permutation and emits the symbol as 2*WIDTH-bit words toward the mapper.

## Interface
- WIDTH, 24, data bits per encoder input word; coded word = 2*WIDTH = 48. Only 24 is legal.
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous reset, active-high
- s_axis_tdata  in  2*WIDTH  coded bits; bit 0 is earliest in time
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake
- s_axis_tlast  in  1  last word of packet
- s_axis_tuser  in  4  802.11a RATE code
- m_axis_tdata  out  2*WIDTH  interleaved bits; bit 0 is first transmitted
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tlast  out  1  last word of last symbol of packet
- m_axis_tuser  out  4  RATE latched for the symbol

## Operation
- Mode from RATE:
  - 1101/1111: N_CBPS=48, N_BPSC=1
  - 0101/0111: N_CBPS=96, N_BPSC=2
  - 1001/1011: N_CBPS=192, N_BPSC=4
  - 0001/0011: N_CBPS=288, N_BPSC=6
  - Any other code: treated as 48/1; m_axis_tuser still carries the raw code.
- Words per symbol: NW = N_CBPS/48 = 1, 2, 4 or 6.
- RATE and mode are sampled on the first accepted word of each symbol. tuser changes within a symbol are ignored.
- Input word w fills buffer bits k = 48w..48w+47.
- Permutation, with s = max(N_BPSC/2, 1):
  - i = (N_CBPS/16)(k mod 16) + floor(k/16)
  - j = s*floor(i/s) + (i + N_CBPS - floor(16i/N_CBPS)) mod s
  - Buffer bit k goes to output bit j.
- Output word v carries j = 48v..48v+47. The symbol's NW output words are emitted in order.
- Fill state machine: FILL → (word NW-1 accepted, or tlast accepted) → FULL → (output buffer free) → FILL.
- Early tlast (fewer than NW words received): remaining bits are zero. The symbol is emitted normally, and m_axis_tlast is set on its final output word only.
- tlast on exactly word NW-1 behaves the same way; the next accepted word starts a new packet.
- Drain state machine: IDLE → SEND (v = 0..NW-1) → IDLE after the last word is accepted.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0. All counters and buffers are cleared.
- s_axis_tready rises on the first aclk edge after areset deasserts.
- Latency: the final input word of a symbol is accepted at edge N; output word 0 is valid after edge N+1.
- One output word per cycle while m_axis_tready=1.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tuser are held stable.
- m_axis_tvalid never drops without a completed transfer.
- Reset mid-symbol: everything partial is discarded; no output is produced for it.
- s_axis_tready is a registered output and does not depend combinationally on m_axis_tready.

## Configuration
- INTERLEAVER_PINGPONG_EN defined:
  - Two 288-bit buffers.
  - The next symbol fills while the previous drains. s_axis_tready=1 unless both buffers hold undrained symbols.
  - Sustained throughput is 1 word/cycle.
- Undefined:
  - Single buffer. s_axis_tready=0 from the FILL→FULL transition until the last output word is accepted.
  - Throughput is NW words per 2*NW+1 cycles.

## Structure
- Shared in ieee80211_defs: the eight RATE code constants, the N_CBPS/N_BPSC lookup function, and localparam CODED_WIDTH=48.
- Sub-module interleaver_perm: purely combinational; 288-bit buffer plus 2-bit mode in, 288-bit permuted vector out. Built as four generate-wired fixed permutations and a mux.
- The top level holds the buffers, counters, both state machines and the handshakes.

## Test plan
- RATE 1101, one word 48'h000000000002, tlast=1 → one output 48'h000000000008 with tlast=1 and tuser=1101, one cycle after acceptance.
- RATE 0101, two words: word0=48'h000000000002, word1=0 → out word0=48'h000000000040, word1=0. Separately, input k=16 → output j=1.
- RATE 1001, four words with only k=1 set → only output bit j=13 set (word0 = 48'h000000002000).
- RATE 0011, six words with only k=1 set → only j=20 set. Then k=0 alone → j=0.
- RATE 0001, tlast on word 2 → six output words, bits from k≥144 are zero, tlast only on output word 5.
- Random m_axis_tready stalls with back-to-back symbols, plus areset asserted mid-symbol:
  - Output must match a software model, with data stable under stall and no lost or duplicated words.
  - After reset, no stale output.
  - With INTERLEAVER_PINGPONG_EN and tready=1, s_axis_tready must never drop.
